// File: rtl/mmcm_drp_ctrl.sv
// Run-time CLKOUT0 divide reprogramming for MMCME2_ADV via DRP read-modify-write.
// Holds the MMCM in reset across the DRP phase and reports completion once LOCKED returns.
module mmcm_drp_ctrl #(
    parameter logic [6:0]  CLKREG1_ADDR = 7'h08,
    parameter logic [6:0]  CLKREG2_ADDR = 7'h09,
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned RST_HOLD     = 8
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [7:0]  i_divide,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic        o_mmcm_rst,
    input  logic        i_mmcm_locked,
    output logic [6:0]  o_drp_daddr,
    output logic        o_drp_den,
    output logic        o_drp_dwe,
    output logic [15:0] o_drp_di,
    input  logic [15:0] i_drp_do,
    input  logic        i_drp_drdy
);

    localparam int unsigned MAX_A = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int unsigned MAX_T = (MAX_A > RST_HOLD) ? MAX_A : RST_HOLD;
    localparam int unsigned TW    = $clog2(MAX_T + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HOLD_RST,
        S_RD1,
        S_WT_RD1,
        S_WR1,
        S_WT_WR1,
        S_RD2,
        S_WT_RD2,
        S_WR2,
        S_WT_WR2,
        S_WAIT_LOCK,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_next;
    logic [TW-1:0]   w_timer_inc;
    logic [7:0]      r_divide;
    logic [7:0]      w_divide_next;
    logic            w_error_next;
    logic            w_busy_next;
    logic            w_done_next;
    logic            w_rst_next;
    logic            w_den_next;
    logic            w_dwe_next;
    logic [6:0]      w_daddr_next;
    logic [15:0]     w_di_next;
    logic [1:0]      r_lock_sync;
    logic            w_drdy_to;
    logic            w_lock_to;
    logic            w_div_bad;
    logic            w_div_one;
    logic [5:0]      w_high;
    logic [5:0]      w_low;
    logic            w_edge;
    logic            w_no_count;
    logic [15:0]     w_di_reg1;
    logic [15:0]     w_di_reg2;

    // LOCKED is asynchronous to i_clock
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lock_sync <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], i_mmcm_locked};
        end
    end

    // Divide field encoding; read data is merged into the untouched bits
    always_comb begin
        w_div_one  = (r_divide == 8'd1);
        w_high     = w_div_one ? 6'd1 : r_divide[6:1];
        w_low      = w_div_one ? 6'd1 : 6'(r_divide - {1'b0, r_divide[7:1]});
        w_edge     = w_div_one ? 1'b0 : r_divide[0];
        w_no_count = w_div_one;
        w_di_reg1  = (i_drp_do & 16'hF000) | {4'b0000, w_high, w_low};
        w_di_reg2  = (i_drp_do & 16'hFF3F) | {8'h00, w_edge, w_no_count, 6'b000000};
    end

    assign w_timer_inc = r_timer + TW'(1);
    assign w_drdy_to   = (r_timer == TW'(DRDY_TIMEOUT - 1));
    assign w_lock_to   = (r_timer == TW'(LOCK_TIMEOUT - 1));
    assign w_div_bad   = (i_divide == 8'd0) || (i_divide > 8'd64);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_divide    <= 8'd0;
            o_error     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_mmcm_rst  <= 1'b0;
            o_drp_den   <= 1'b0;
            o_drp_dwe   <= 1'b0;
            o_drp_daddr <= 7'd0;
            o_drp_di    <= 16'd0;
        end else begin
            r_state     <= w_next_state;
            r_timer     <= w_timer_next;
            r_divide    <= w_divide_next;
            o_error     <= w_error_next;
            o_busy      <= w_busy_next;
            o_done      <= w_done_next;
            o_mmcm_rst  <= w_rst_next;
            o_drp_den   <= w_den_next;
            o_drp_dwe   <= w_dwe_next;
            o_drp_daddr <= w_daddr_next;
            o_drp_di    <= w_di_next;
        end
    end

    // Next state; registered outputs are decoded from the next state so they align with r_state
    always_comb begin
        w_next_state  = r_state;
        w_timer_next  = '0;
        w_divide_next = r_divide;
        w_error_next  = o_error;
        w_den_next    = 1'b0;
        w_dwe_next    = 1'b0;
        w_daddr_next  = 7'd0;
        w_di_next     = 16'd0;

        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_divide_next = i_divide;
                    w_error_next  = w_div_bad;
                    if (!w_div_bad) begin
                        w_next_state = S_HOLD_RST;
                    end
                end
            end
            S_HOLD_RST: begin
                if (r_timer == TW'(RST_HOLD - 1)) begin
                    w_next_state = S_RD1;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            S_RD1: w_next_state = S_WT_RD1;
            S_WR1: w_next_state = S_WT_WR1;
            S_RD2: w_next_state = S_WT_RD2;
            S_WR2: w_next_state = S_WT_WR2;
            S_WT_RD1, S_WT_WR1, S_WT_RD2, S_WT_WR2: begin
                if (i_drp_drdy) begin
                    unique case (r_state)
                        S_WT_RD1: w_next_state = S_WR1;
                        S_WT_WR1: w_next_state = S_RD2;
                        S_WT_RD2: w_next_state = S_WR2;
                        default:  w_next_state = S_WAIT_LOCK;
                    endcase
                end else if (w_drdy_to) begin
                    w_error_next = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            S_WAIT_LOCK: begin
                if (r_lock_sync[1]) begin
                    w_next_state = S_DONE;
                end else if (w_lock_to) begin
                    w_error_next = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase

        unique case (w_next_state)
            S_RD1: begin
                w_den_next   = 1'b1;
                w_daddr_next = CLKREG1_ADDR;
            end
            S_WR1: begin
                w_den_next   = 1'b1;
                w_dwe_next   = 1'b1;
                w_daddr_next = CLKREG1_ADDR;
                w_di_next    = w_di_reg1;
            end
            S_RD2: begin
                w_den_next   = 1'b1;
                w_daddr_next = CLKREG2_ADDR;
            end
            S_WR2: begin
                w_den_next   = 1'b1;
                w_dwe_next   = 1'b1;
                w_daddr_next = CLKREG2_ADDR;
                w_di_next    = w_di_reg2;
            end
            default: ;
        endcase

        w_busy_next = (w_next_state != S_IDLE);
        w_done_next = (w_next_state == S_DONE);
        w_rst_next  = (w_next_state != S_IDLE) && (w_next_state != S_WAIT_LOCK) &&
                      (w_next_state != S_DONE);
    end

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Directed bench for mmcm_drp_ctrl with a DRP slave model and a simple MMCM lock model.
module tb_mmcm_drp_ctrl;

    localparam int unsigned LOCK_TO  = 1024;
    localparam int unsigned DRDY_LAT = 2;
    localparam int unsigned LOCK_DLY = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  divide = 8'd0;
    logic        busy, done, err, mmcm_rst, den, dwe;
    logic        locked = 1'b0;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] ddo = 16'hDEAD;
    logic        drdy = 1'b0;

    always #5 clk = ~clk;

    mmcm_drp_ctrl #(.LOCK_TIMEOUT(LOCK_TO)) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_start       (start),
        .i_divide      (divide),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (err),
        .o_mmcm_rst    (mmcm_rst),
        .i_mmcm_locked (locked),
        .o_drp_daddr   (daddr),
        .o_drp_den     (den),
        .o_drp_dwe     (dwe),
        .o_drp_di      (di),
        .i_drp_do      (ddo),
        .i_drp_drdy    (drdy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] outs();
        return 32'({busy, done, err, mmcm_rst, den, dwe, daddr, di});
    endfunction

    // DRP slave model
    logic [15:0] reg1_val = 16'h0000;
    logic [15:0] reg2_val = 16'h0000;
    bit          withhold_wr = 1'b0;
    bit          withheld = 1'b0;
    bit          hold_low = 1'b0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic        pend_we = 1'b0;
    logic [6:0]  pend_addr = 7'd0;
    int          cyc = 0;
    int          busy_n = 0;
    int          done_n = 0;
    int          rstc_n = 0;
    int          last_den_cyc = 0;
    int          lk_cnt = 0;
    logic [6:0]  den_addr_q[$];
    logic        den_we_q[$];
    logic [15:0] den_di_q[$];

    always @(posedge clk) begin
        cyc++;
        drdy <= 1'b0;
        ddo  <= 16'hDEAD;
        if (busy) busy_n++;
        if (done) done_n++;
        if (mmcm_rst) rstc_n++;
        if (pend) begin
            if (pend_cnt <= 1) begin
                drdy <= 1'b1;
                ddo  <= pend_we ? 16'h0000 : ((pend_addr == 7'h08) ? reg1_val : reg2_val);
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (den) begin
            check("den_overlap", 32'(pend), 32'd0);
            check("rst_in_drp", 32'(mmcm_rst), 32'd1);
            last_den_cyc = cyc;
            den_addr_q.push_back(daddr);
            den_we_q.push_back(dwe);
            den_di_q.push_back(di);
            if (dwe && withhold_wr && !withheld) begin
                withheld = 1'b1;
            end else begin
                pend      = 1'b1;
                pend_cnt  = DRDY_LAT;
                pend_we   = dwe;
                pend_addr = daddr;
            end
        end
    end

    // MMCM lock model: drops in reset, relocks LOCK_DLY cycles after release
    always @(posedge clk) begin
        if (mmcm_rst || hold_low) begin
            locked <= 1'b0;
            lk_cnt = 0;
        end else if (!locked) begin
            lk_cnt++;
            if (lk_cnt >= LOCK_DLY) locked <= 1'b1;
        end
    end

    task automatic do_start(input logic [7:0] d);
        @(negedge clk);
        start  = 1'b1;
        divide = d;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit got_done, output bit got_err, output int cycles);
        cycles = 0;
        while (cycles < budget && !done && !err) begin
            @(negedge clk);
            cycles++;
        end
        got_done = done;
        got_err  = err;
    endtask

    task automatic check_seq(input string tag, input int base,
                             input logic [15:0] w1, input logic [15:0] w2);
        check({tag, "_den_cnt"}, 32'(den_addr_q.size() - base), 32'd4);
        check({tag, "_rd1"}, 32'({den_we_q[base], den_addr_q[base]}), 32'h08);
        check({tag, "_wr1_addr"}, 32'({den_we_q[base+1], den_addr_q[base+1]}), 32'h88);
        check({tag, "_wr1_data"}, 32'(den_di_q[base+1]), 32'(w1));
        check({tag, "_rd2"}, 32'({den_we_q[base+2], den_addr_q[base+2]}), 32'h09);
        check({tag, "_wr2_addr"}, 32'({den_we_q[base+3], den_addr_q[base+3]}), 32'h89);
        check({tag, "_wr2_data"}, 32'(den_di_q[base+3]), 32'(w2));
    endtask

    initial begin
        int base;
        int cycles;
        int k;
        int b0;
        int r0;
        int d0;
        bit gd;
        bit ge;

        #12;
        check("reset_outs", outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // divide 5, typical readback
        reg1_val = 16'hF000;
        reg2_val = 16'h3C3F;
        base = den_addr_q.size();
        do_start(8'd5);
        check("t1_busy_rst", 32'({busy, mmcm_rst}), 32'h3);
        wait_end(2000, gd, ge, cycles);
        check("t1_done_err", 32'({gd, ge}), 32'h2);
        check("t1_rst_at_done", 32'(mmcm_rst), 32'd0);
        check_seq("t1", base, 16'hF083, 16'h3CBF);
        @(negedge clk);
        check("t1_after_done", 32'({busy, done}), 32'h0);

        // divide 1
        reg1_val = 16'h0000;
        reg2_val = 16'h0000;
        base = den_addr_q.size();
        do_start(8'd1);
        wait_end(2000, gd, ge, cycles);
        check("t2_done_err", 32'({gd, ge}), 32'h2);
        check_seq("t2", base, 16'h0041, 16'h0040);

        // out-of-range divides
        base = den_addr_q.size();
        b0 = busy_n;
        r0 = rstc_n;
        do_start(8'd0);
        check("t3_div0_err", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        do_start(8'd65);
        check("t3_div65_err", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        check("t3_no_den", 32'(den_addr_q.size() - base), 32'd0);
        check("t3_no_rst", 32'(rstc_n - r0), 32'd0);
        check("t3_busy_short", 32'((busy_n - b0) <= 2), 32'd1);

        // first write never acknowledged
        reg1_val = 16'hF000;
        reg2_val = 16'h3C3F;
        withheld = 1'b0;
        withhold_wr = 1'b1;
        base = den_addr_q.size();
        d0 = done_n;
        do_start(8'd5);
        check("t4_err_cleared", 32'(err), 32'd0);
        wait_end(500, gd, ge, cycles);
        check("t4_done_err", 32'({gd, ge}), 32'h1);
        check("t4_to_len", 32'((cyc - last_den_cyc) >= 60 && (cyc - last_den_cyc) <= 70), 32'd1);
        check("t4_den_cnt", 32'(den_addr_q.size() - base), 32'd2);
        check("t4_idle", 32'({busy, mmcm_rst}), 32'h0);
        withhold_wr = 1'b0;
        repeat (20) @(negedge clk);
        check("t4_no_done", 32'(done_n - d0), 32'd0);
        base = den_addr_q.size();
        do_start(8'd5);
        check("t4b_err_cleared", 32'(err), 32'd0);
        wait_end(2000, gd, ge, cycles);
        check("t4b_done_err", 32'({gd, ge}), 32'h2);
        check_seq("t4b", base, 16'hF083, 16'h3CBF);

        // LOCKED never returns
        hold_low = 1'b1;
        do_start(8'd5);
        wait_end(LOCK_TO + 400, gd, ge, cycles);
        check("t5_done_err", 32'({gd, ge}), 32'h1);
        check("t5_to_len", 32'(cycles >= LOCK_TO && cycles <= LOCK_TO + 100), 32'd1);
        check("t5_idle", 32'({busy, mmcm_rst}), 32'h0);
        hold_low = 1'b0;
        repeat (20) @(negedge clk);

        // second start while busy is ignored
        base = den_addr_q.size();
        d0 = done_n;
        do_start(8'd5);
        repeat (3) @(negedge clk);
        do_start(8'd7);
        wait_end(2000, gd, ge, cycles);
        check("t6_done_err", 32'({gd, ge}), 32'h2);
        check_seq("t6", base, 16'hF083, 16'h3CBF);
        repeat (60) @(negedge clk);
        check("t6_one_done", 32'(done_n - d0), 32'd1);
        check("t6_idle", 32'(busy), 32'd0);

        // async reset while waiting on the ClkReg2 read
        do_start(8'd5);
        k = 0;
        while (k < 500 && !(den && daddr == 7'h09 && !dwe)) begin
            @(negedge clk);
            k++;
        end
        check("t7_reach_rd2", 32'(k < 500), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("t7_async_clear", outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t7_idle_after", outs(), 32'd0);
        base = den_addr_q.size();
        do_start(8'd1);
        wait_end(2000, gd, ge, cycles);
        check("t7_done_err", 32'({gd, ge}), 32'h2);
        check_seq("t7", base, 16'hF041, 16'h3C7F);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
